ball_split_ctrl: RTL and testbench
==================================

BALL_SPLIT_CTRL -- requirements
Module: ball_split_ctrl

Interface
REQ-001 Parameter X_OFFSET, default 16, horizontal pixel offset of each child from the parent.
REQ-002 Parameter MIN_KICK, default 40, minimum upward speed magnitude given to children.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles to wait for child_ready.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-007 hit_req  in  1  parent ball hit by rope; level-held until hit_ack.
REQ-008 hit_ack  out  1  one-cycle pulse: request accepted.
REQ-009 parent_x, parent_y  in  16 signed  parent top-left position.
REQ-010 parent_xspeed, parent_yspeed  in  16 signed  parent speeds.
REQ-011 parent_level  in  2  size code: 3 huge, 2 big, 1 medium, 0 small.
REQ-012 child_ready  in  1  target ball slot can accept a load.
REQ-013 child_load  out  1  one-cycle load strobe to ball slot.
REQ-014 child_sel  out  1  0 selects child 1, 1 selects child 2.
REQ-015 child_x, child_y, child_xspeed, child_yspeed  out  16 signed  values to load.
REQ-016 child_level  out  2  size code of the loaded child.
REQ-017 pop_pulse  out  1  one-cycle pulse: smallest ball destroyed.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 err_timeout  out  1  sticky flag: a load timed out.
REQ-020 split_count  out  8  splits completed, saturating at 255.

Function
REQ-021 FSM states SHALL be IDLE, CAPTURE, LOAD1, LOAD2, POP and COOLDOWN.
REQ-022 IDLE -> CAPTURE when hit_req=1; inputs are latched on that edge and hit_ack=1 for exactly the CAPTURE cycle.
REQ-023 hit_req in any state other than IDLE SHALL be ignored, with no ack.
REQ-024 CAPTURE -> POP if latched level=0, else -> LOAD1.
REQ-025 POP: pop_pulse=1 for one cycle, then -> COOLDOWN.
REQ-026 LOAD1/LOAD2: child_sel=0/1 and outputs valid throughout; child_load=1 only on the cycle child_ready=1, then -> next state (LOAD1 -> LOAD2 -> COOLDOWN).
REQ-027 Child speed: child1 xspeed = X, child2 xspeed = -X; -(-32768) SHALL saturate to 32767.
REQ-028 Child yspeed for both children = -max(|Y|, MIN_KICK), so always upward; |-32768| saturates to 32767.
REQ-029 Child x: child1 = parent_x + X_OFFSET saturating at 32767; child2 = parent_x - X_OFFSET clamped at 0; child_y = parent_y for both.
REQ-030 child_level = latched level - 1.
REQ-031 Wait counter reset on entry to LOAD1/LOAD2; if TIMEOUT cycles pass without child_ready, set err_timeout and -> COOLDOWN with no load.
REQ-032 split_count increments by 1 on the LOAD2 load strobe only, holding at 255.
REQ-033 COOLDOWN -> IDLE on the first startOfFrame pulse after entry; startOfFrame in the same cycle as entry does not count.
REQ-034 Latched values SHALL be stable from CAPTURE until IDLE regardless of parent input changes.

Reset
REQ-035 On reset=1, asynchronously: state IDLE; hit_ack, child_load, pop_pulse, busy, err_timeout and child_sel are 0; split_count 0; all latched data and child outputs 0.
REQ-036 Reset mid-operation SHALL abort with no further strobes; err_timeout is cleared only by reset.

Verification
REQ-037 Level 3, X=5, Y=20, x=100, y=50, child_ready=1 -> ack; load child1 (116, 50, 5, -40, level 2), then child2 (84, 50, -5, -40, level 2); split_count=1.
REQ-038 Level 0 hit -> one pop_pulse, no child_load, split_count unchanged.
REQ-039 X=-32768, Y=-100, x=5 -> child2 xspeed 32767, child2 x 0, child yspeed -100.
REQ-040 child_ready held 0 for 300 cycles -> err_timeout=1 after 255 cycles of waiting in LOAD1, no load, then IDLE after the next startOfFrame.
REQ-041 Second hit_req during LOAD2 and COOLDOWN -> no ack; accepted only after return to IDLE.
REQ-042 Reset asserted in LOAD1 -> all outputs 0 immediately; a new hit after release gives normal behaviour.

Source files
------------

// File: rtl/ball_split_ctrl_if.sv
// Interface between the ball-split controller and the game logic / ball slots.
// The master modport drives hits and ready; the slave modport is the controller.
interface ball_split_ctrl_if;
   logic               startOfFrame;
   logic               hit_req;
   logic               hit_ack;
   logic signed [15:0] parent_x;
   logic signed [15:0] parent_y;
   logic signed [15:0] parent_xspeed;
   logic signed [15:0] parent_yspeed;
   logic [1:0]         parent_level;
   logic               child_ready;
   logic               child_load;
   logic               child_sel;
   logic signed [15:0] child_x;
   logic signed [15:0] child_y;
   logic signed [15:0] child_xspeed;
   logic signed [15:0] child_yspeed;
   logic [1:0]         child_level;
   logic               pop_pulse;
   logic               busy;
   logic               err_timeout;
   logic [7:0]         split_count;

   modport master (
      output startOfFrame, hit_req, parent_x, parent_y, parent_xspeed, parent_yspeed,
             parent_level, child_ready,
      input  hit_ack, child_load, child_sel, child_x, child_y, child_xspeed, child_yspeed,
             child_level, pop_pulse, busy, err_timeout, split_count
   );

   modport slave (
      input  startOfFrame, hit_req, parent_x, parent_y, parent_xspeed, parent_yspeed,
             parent_level, child_ready,
      output hit_ack, child_load, child_sel, child_x, child_y, child_xspeed, child_yspeed,
             child_level, pop_pulse, busy, err_timeout, split_count
   );
endinterface

// File: rtl/ball_split_ctrl.sv
// Splits a hit ball into two smaller children loaded into ball slots one after another,
// or pops it when it is already the smallest size.
module ball_split_ctrl #(
   parameter int          X_OFFSET = 16,
   parameter int          MIN_KICK = 40,
   parameter int unsigned TIMEOUT  = 255
) (
   input logic              i_clk,
   input logic              i_reset,
   ball_split_ctrl_if.slave bus
);
   localparam int CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic signed [17:0] XOff    = 18'(X_OFFSET);
   localparam logic signed [15:0] MinKick = 16'(MIN_KICK);

   typedef enum logic [2:0] {StIdle, StCapture, StLoad1, StLoad2, StPop, StCooldown} state_e;

   state_e             r_state, w_state_next;
   logic signed [15:0] r_px, r_py, r_pxs, r_pys;
   logic [1:0]         r_level;
   logic [CntW-1:0]    r_wait, w_wait_next;
   logic               r_cd_armed;
   logic               r_err;
   logic [7:0]         r_split;
   logic               w_load, w_timeout, w_in_load;

   logic signed [17:0] w_px_ext, w_x1_wide, w_x2_wide;
   logic signed [15:0] w_x1, w_x2, w_xs_neg, w_ys_abs, w_ys_mag;

   assign w_px_ext  = r_px;
   assign w_x1_wide = w_px_ext + XOff;
   assign w_x2_wide = w_px_ext - XOff;
   assign w_x1 = (w_x1_wide > 18'sd32767) ? 16'sh7fff :
                 (w_x1_wide < -18'sd32768) ? 16'sh8000 : w_x1_wide[15:0];
   assign w_x2 = (w_x2_wide < 18'sd0)     ? 16'sh0000 :
                 (w_x2_wide > 18'sd32767) ? 16'sh7fff : w_x2_wide[15:0];

   // Negating the most negative value would wrap, so it saturates instead.
   assign w_xs_neg = (r_pxs == 16'sh8000) ? 16'sh7fff : -r_pxs;
   assign w_ys_abs = (r_pys == 16'sh8000) ? 16'sh7fff : (r_pys[15] ? -r_pys : r_pys);
   assign w_ys_mag = (w_ys_abs < MinKick) ? MinKick : w_ys_abs;

   always_comb begin
      w_state_next = r_state;
      w_wait_next  = r_wait;
      w_load       = 1'b0;
      w_timeout    = 1'b0;
      unique case (r_state)
         StIdle:    if (bus.hit_req) w_state_next = StCapture;
         StCapture: begin
            w_wait_next  = '0;
            w_state_next = (r_level == 2'd0) ? StPop : StLoad1;
         end
         StLoad1, StLoad2: begin
            if (bus.child_ready) begin
               w_load       = 1'b1;
               w_wait_next  = '0;
               w_state_next = (r_state == StLoad1) ? StLoad2 : StCooldown;
            end else if (r_wait == CntW'(TIMEOUT - 1)) begin
               w_timeout    = 1'b1;
               w_state_next = StCooldown;
            end else begin
               w_wait_next = r_wait + 1'b1;
            end
         end
         StPop:      w_state_next = StCooldown;
         // The frame pulse coinciding with the entry cycle is deliberately ignored.
         StCooldown: if (r_cd_armed && bus.startOfFrame) w_state_next = StIdle;
         default:    w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_px       <= '0;
         r_py       <= '0;
         r_pxs      <= '0;
         r_pys      <= '0;
         r_level    <= '0;
         r_wait     <= '0;
         r_cd_armed <= 1'b0;
         r_err      <= 1'b0;
         r_split    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_wait     <= w_wait_next;
         r_cd_armed <= (r_state == StCooldown);
         if (r_state == StIdle && bus.hit_req) begin
            r_px    <= bus.parent_x;
            r_py    <= bus.parent_y;
            r_pxs   <= bus.parent_xspeed;
            r_pys   <= bus.parent_yspeed;
            r_level <= bus.parent_level;
         end
         if (w_timeout) r_err <= 1'b1;
         if (w_load && r_state == StLoad2 && r_split != 8'hff) r_split <= r_split + 8'd1;
      end
   end

   // Child outputs are forced to zero outside the load states.
   assign w_in_load        = (r_state == StLoad1) || (r_state == StLoad2);
   assign bus.hit_ack      = (r_state == StCapture);
   assign bus.pop_pulse    = (r_state == StPop);
   assign bus.busy         = (r_state != StIdle);
   assign bus.child_load   = w_load;
   assign bus.child_sel    = (r_state == StLoad2);
   assign bus.child_x      = !w_in_load ? 16'sh0 : (bus.child_sel ? w_x2 : w_x1);
   assign bus.child_y      = w_in_load ? r_py : 16'sh0;
   assign bus.child_xspeed = !w_in_load ? 16'sh0 : (bus.child_sel ? w_xs_neg : r_pxs);
   assign bus.child_yspeed = w_in_load ? -w_ys_mag : 16'sh0;
   assign bus.child_level  = w_in_load ? (r_level - 2'd1) : 2'd0;
   assign bus.err_timeout  = r_err;
   assign bus.split_count  = r_split;
endmodule

// File: tb/tb_ball_split_ctrl.sv
// Directed bench for ball_split_ctrl with hand-computed expected values.
module tb_ball_split_ctrl;
   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic any_load;

   ball_split_ctrl_if bus ();

   ball_split_ctrl #(
      .X_OFFSET(16),
      .MIN_KICK(40),
      .TIMEOUT (255)
   ) dut (
      .i_clk  (clk),
      .i_reset(reset),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_parent(input int x, input int y, input int xs, input int ys,
                             input int lvl);
      bus.parent_x      = 16'(x);
      bus.parent_y      = 16'(y);
      bus.parent_xspeed = 16'(xs);
      bus.parent_yspeed = 16'(ys);
      bus.parent_level  = 2'(lvl);
   endtask

   // Called from an armed COOLDOWN cycle: one frame pulse returns to IDLE.
   task automatic finish_frame(input string tag);
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      check_eq(tag, int'(bus.busy), 0);
   endtask

   initial begin
      reset            = 1'b1;
      bus.startOfFrame = 1'b0;
      bus.hit_req      = 1'b0;
      bus.child_ready  = 1'b0;
      set_parent(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", int'(bus.busy), 0);
      check_eq("rst_ack", int'(bus.hit_ack), 0);
      check_eq("rst_load", int'(bus.child_load), 0);
      check_eq("rst_split", int'(bus.split_count), 0);
      check_eq("rst_err", int'(bus.err_timeout), 0);
      check_eq("rst_cx", int'(bus.child_x), 0);
      reset = 1'b0;
      tick();

      // Level 3 split with scrambled parent inputs after capture
      set_parent(100, 50, 5, 20, 3);
      bus.child_ready = 1'b1;
      bus.hit_req     = 1'b1;
      tick();
      check_eq("t1_ack", int'(bus.hit_ack), 1);
      check_eq("t1_busy", int'(bus.busy), 1);
      check_eq("t1_noload_cap", int'(bus.child_load), 0);
      bus.hit_req = 1'b0;
      set_parent(-7, -7, 99, 99, 0);
      tick();
      check_eq("t1_c1_load", int'(bus.child_load), 1);
      check_eq("t1_c1_sel", int'(bus.child_sel), 0);
      check_eq("t1_c1_x", int'(bus.child_x), 116);
      check_eq("t1_c1_y", int'(bus.child_y), 50);
      check_eq("t1_c1_xs", int'(bus.child_xspeed), 5);
      check_eq("t1_c1_ys", int'(bus.child_yspeed), -40);
      check_eq("t1_c1_lvl", int'(bus.child_level), 2);
      check_eq("t1_ack_once", int'(bus.hit_ack), 0);
      tick();
      check_eq("t1_c2_load", int'(bus.child_load), 1);
      check_eq("t1_c2_sel", int'(bus.child_sel), 1);
      check_eq("t1_c2_x", int'(bus.child_x), 84);
      check_eq("t1_c2_y", int'(bus.child_y), 50);
      check_eq("t1_c2_xs", int'(bus.child_xspeed), -5);
      check_eq("t1_c2_ys", int'(bus.child_yspeed), -40);
      check_eq("t1_c2_lvl", int'(bus.child_level), 2);
      tick();
      check_eq("t1_cd_load", int'(bus.child_load), 0);
      check_eq("t1_split", int'(bus.split_count), 1);
      check_eq("t1_cd_busy", int'(bus.busy), 1);
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      check_eq("t1_sof_entry_ignored", int'(bus.busy), 1);
      finish_frame("t1_idle");

      // Smallest ball pops
      set_parent(10, 10, 1, 1, 0);
      bus.hit_req = 1'b1;
      tick();
      check_eq("t2_ack", int'(bus.hit_ack), 1);
      bus.hit_req = 1'b0;
      tick();
      check_eq("t2_pop", int'(bus.pop_pulse), 1);
      check_eq("t2_pop_noload", int'(bus.child_load), 0);
      tick();
      check_eq("t2_pop_once", int'(bus.pop_pulse), 0);
      check_eq("t2_cd_noload", int'(bus.child_load), 0);
      check_eq("t2_split", int'(bus.split_count), 1);
      tick();
      finish_frame("t2_idle");

      // Speed negation saturation and left clamp
      set_parent(5, 7, -32768, -100, 2);
      bus.hit_req = 1'b1;
      tick();
      check_eq("t3_ack", int'(bus.hit_ack), 1);
      bus.hit_req = 1'b0;
      tick();
      check_eq("t3_c1_xs", int'(bus.child_xspeed), -32768);
      check_eq("t3_c1_x", int'(bus.child_x), 21);
      check_eq("t3_c1_ys", int'(bus.child_yspeed), -100);
      check_eq("t3_c1_lvl", int'(bus.child_level), 1);
      tick();
      check_eq("t3_c2_xs", int'(bus.child_xspeed), 32767);
      check_eq("t3_c2_x", int'(bus.child_x), 0);
      check_eq("t3_c2_ys", int'(bus.child_yspeed), -100);
      tick();
      check_eq("t3_split", int'(bus.split_count), 2);
      tick();
      finish_frame("t3_idle");

      // Right saturation of x and |-32768| on yspeed
      set_parent(32760, -3, 0, -32768, 1);
      bus.hit_req = 1'b1;
      tick();
      bus.hit_req = 1'b0;
      tick();
      check_eq("t3b_c1_x", int'(bus.child_x), 32767);
      check_eq("t3b_c1_y", int'(bus.child_y), -3);
      check_eq("t3b_c1_ys", int'(bus.child_yspeed), -32767);
      check_eq("t3b_c1_lvl", int'(bus.child_level), 0);
      tick();
      check_eq("t3b_c2_x", int'(bus.child_x), 32744);
      check_eq("t3b_c2_xs", int'(bus.child_xspeed), 0);
      tick();
      check_eq("t3b_split", int'(bus.split_count), 3);
      tick();
      finish_frame("t3b_idle");

      // Timeout in LOAD1: 255 waiting cycles, then COOLDOWN with sticky error
      bus.child_ready = 1'b0;
      set_parent(100, 50, 5, 20, 2);
      bus.hit_req = 1'b1;
      tick();
      bus.hit_req = 1'b0;
      tick();
      any_load = bus.child_load;
      repeat (254) begin
         tick();
         if (bus.child_load) any_load = 1'b1;
      end
      check_eq("t4_no_load_waiting", int'(any_load), 0);
      check_eq("t4_still_load1", int'(bus.child_level), 1);
      check_eq("t4_no_err_yet", int'(bus.err_timeout), 0);
      tick();
      check_eq("t4_err", int'(bus.err_timeout), 1);
      check_eq("t4_left_load1", int'(bus.child_level), 0);
      check_eq("t4_cd_busy", int'(bus.busy), 1);
      repeat (40) tick();
      check_eq("t4_cd_wait_sof", int'(bus.busy), 1);
      finish_frame("t4_idle");
      check_eq("t4_err_sticky", int'(bus.err_timeout), 1);
      check_eq("t4_split", int'(bus.split_count), 3);

      // hit_req held through the whole operation: only re-acked from IDLE
      bus.child_ready = 1'b1;
      set_parent(100, 50, 5, 20, 1);
      bus.hit_req = 1'b1;
      tick();
      check_eq("t5_ack", int'(bus.hit_ack), 1);
      tick();
      check_eq("t5_l1_noack", int'(bus.hit_ack), 0);
      tick();
      check_eq("t5_l2_noack", int'(bus.hit_ack), 0);
      check_eq("t5_l2_load", int'(bus.child_load), 1);
      tick();
      check_eq("t5_cd_noack", int'(bus.hit_ack), 0);
      check_eq("t5_split", int'(bus.split_count), 4);
      tick();
      check_eq("t5_cd2_noack", int'(bus.hit_ack), 0);
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      check_eq("t5_idle_noack", int'(bus.hit_ack), 0);
      check_eq("t5_idle", int'(bus.busy), 0);
      tick();
      check_eq("t5_reack", int'(bus.hit_ack), 1);
      bus.hit_req = 1'b0;
      repeat (3) tick();
      check_eq("t5_split2", int'(bus.split_count), 5);
      tick();
      finish_frame("t5_idle2");

      // Asynchronous reset during LOAD1
      bus.child_ready = 1'b0;
      set_parent(100, 50, 5, 20, 2);
      bus.hit_req = 1'b1;
      tick();
      bus.hit_req = 1'b0;
      tick();
      check_eq("t6_in_load1", int'(bus.child_level), 1);
      #1 reset = 1'b1;
      #1;
      check_eq("t6_rst_busy", int'(bus.busy), 0);
      check_eq("t6_rst_lvl", int'(bus.child_level), 0);
      check_eq("t6_rst_x", int'(bus.child_x), 0);
      check_eq("t6_rst_err", int'(bus.err_timeout), 0);
      check_eq("t6_rst_split", int'(bus.split_count), 0);
      check_eq("t6_rst_ack", int'(bus.hit_ack), 0);
      tick();
      reset = 1'b0;
      bus.child_ready = 1'b1;
      tick();
      check_eq("t6_post_idle", int'(bus.busy), 0);
      check_eq("t6_post_noload", int'(bus.child_load), 0);
      set_parent(100, 50, 5, 20, 3);
      bus.hit_req = 1'b1;
      tick();
      check_eq("t6_ack", int'(bus.hit_ack), 1);
      bus.hit_req = 1'b0;
      tick();
      check_eq("t6_c1_x", int'(bus.child_x), 116);
      tick();
      check_eq("t6_c2_x", int'(bus.child_x), 84);
      tick();
      check_eq("t6_split", int'(bus.split_count), 1);
      tick();
      finish_frame("t6_idle");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
